// File: rtl/serial_sub16_pkg.sv
// Shared constants, state encoding and overflow helper for the digit-serial subtractor.
package serial_sub16_pkg;

  localparam int WIDTH = 16;
  localparam int DIGIT = 4;
  localparam int NDIG  = WIDTH / DIGIT;
  localparam int CNT_W = $clog2(NDIG);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
    return (a_msb != b_msb) && (d_msb != a_msb);
  endfunction

endpackage

// File: rtl/sub_slice.sv
// Combinational DIGIT-bit ripple-borrow subtractor: d = x - y - bin.
module sub_slice #(
  parameter int DIGIT = serial_sub16_pkg::DIGIT
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             bin,
  output logic [DIGIT-1:0] d,
  output logic             bout
);

  logic [DIGIT:0] bc;

  always_comb begin
    bc    = '0;
    d     = '0;
    bc[0] = bin;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      d[i]    = x[i] ^ y[i] ^ bc[i];
      bc[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & bc[i]);
    end
    bout = bc[DIGIT];
  end

endmodule

// File: rtl/serial_sub16.sv
// Digit-serial subtractor D = A - B - Bi behind a start/done handshake; one slice per clock, LSB first.
module serial_sub16 #(
  parameter int WIDTH = serial_sub16_pkg::WIDTH,
  parameter int DIGIT = serial_sub16_pkg::DIGIT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bi,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bo,
  output logic             V
);

  import serial_sub16_pkg::*;

  localparam int NSL      = WIDTH / DIGIT;
  localparam int CNT_BITS = (NSL > 1) ? $clog2(NSL) : 1;

  logic [1:0]             state;
  logic [CNT_BITS-1:0]    cnt;
  logic [WIDTH-1:0]       a_sh;
  logic [WIDTH-1:0]       b_sh;
  logic [WIDTH-DIGIT-1:0] res;
  logic                   borrow;
  logic [DIGIT-1:0]       sd;
  logic                   sbout;
  logic                   last;

  sub_slice #(.DIGIT(DIGIT)) u_slice (
    .x    (a_sh[DIGIT-1:0]),
    .y    (b_sh[DIGIT-1:0]),
    .bin  (borrow),
    .d    (sd),
    .bout (sbout)
  );

  assign last = (cnt == CNT_BITS'(NSL - 1));
  assign busy = (state == RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      res    <= '0;
      borrow <= 1'b0;
      done   <= 1'b0;
      D      <= '0;
      Bo     <= 1'b0;
      V      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_sh   <= A;
            b_sh   <= B;
            borrow <= Bi;
            cnt    <= '0;
            state  <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> DIGIT;
          b_sh   <= b_sh >> DIGIT;
          borrow <= sbout;
          res    <= {sd, res[WIDTH-DIGIT-1:DIGIT]};
          cnt    <= cnt + 1'b1;
          if (last) begin
            // On the final slice the low digit of the A/B regs is the operands' top digit,
            // so their MSBs feed the overflow check directly.
            D     <= {sd, res};
            Bo    <= sbout;
            V     <= signed_ovf(a_sh[DIGIT-1], b_sh[DIGIT-1], sd[DIGIT-1]);
            done  <= 1'b1;
            cnt   <= '0;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub16.sv
// Directed bench for serial_sub16 with a timing/arithmetic reference model checked every cycle.
module tb_serial_sub16;

  localparam int NDIG = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] A, B;
  logic        Bi;
  logic        busy, done, Bo, V;
  logic [15:0] D;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bi;
    int          e0;
  } op_t;

  op_t  q[$];
  bit   m_rst = 1'b1;
  logic [15:0] ex_D = '0;
  logic        ex_Bo = 1'b0, ex_V = 1'b0;
  logic        e_busy, e_done;
  logic [16:0] full;

  serial_sub16 dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .A     (A),
    .B     (B),
    .Bi    (Bi),
    .busy  (busy),
    .done  (done),
    .D     (D),
    .Bo    (Bo),
    .V     (V)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", nm, $time, act, exp);
    end
  endtask

  // Model: an op is accepted on an edge unless one of the previous NDIG edges started a run.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (reset) begin
      q.delete();
      m_rst = 1'b1;
    end else begin
      m_rst = 1'b0;
      if (start && !(q.size() > 0 && (cyc - 1) >= q[0].e0 && (cyc - 1) <= q[0].e0 + NDIG - 1))
        q.push_back('{a: A, b: B, bi: Bi, e0: cyc});
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      e_busy = 1'b0;
      e_done = 1'b0;
      if (m_rst) begin
        ex_D  = '0;
        ex_Bo = 1'b0;
        ex_V  = 1'b0;
      end else if (q.size() > 0) begin
        if (cyc >= q[0].e0 && cyc <= q[0].e0 + NDIG - 1) e_busy = 1'b1;
        if (cyc == q[0].e0 + NDIG) begin
          e_done = 1'b1;
          full   = {1'b0, q[0].a} - {1'b0, q[0].b} - {16'd0, q[0].bi};
          ex_D   = full[15:0];
          ex_Bo  = full[16];
          ex_V   = (q[0].a[15] != q[0].b[15]) && (full[15] != q[0].a[15]);
          void'(q.pop_front());
        end
      end
      check("m_busy", {31'd0, busy}, {31'd0, e_busy});
      check("m_done", {31'd0, done}, {31'd0, e_done});
      check("m_D",    {16'd0, D},    {16'd0, ex_D});
      check("m_Bo",   {31'd0, Bo},   {31'd0, ex_Bo});
      check("m_V",    {31'd0, V},    {31'd0, ex_V});
    end
  end

  // Called at a negedge; returns at the negedge where done is seen (DUT in DONE).
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic bi,
                       input logic [15:0] ed, input logic ebo, input logic ev, input string nm);
    int n;
    string lbl;
    A = a; B = b; Bi = bi; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    lbl = $sformatf("%s A=%h B=%h Bi=%0d", nm, a, b, bi);
    check({lbl, " latency"}, n, 4);
    check({lbl, " D"},  {16'd0, D},  {16'd0, ed});
    check({lbl, " Bo"}, {31'd0, Bo}, {31'd0, ebo});
    check({lbl, " V"},  {31'd0, V},  {31'd0, ev});
  endtask

  initial begin
    logic [15:0] a, b;
    logic        bi;
    logic [16:0] f;
    int          n;
    reset = 1'b1; start = 1'b0; A = '0; B = '0; Bi = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset_D", {16'd0, D}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);

    do_op(16'd50,    16'd15,    1'b0, 16'd35,    1'b0, 1'b0, "t1");
    @(negedge clk);
    do_op(16'd0,     16'd1,     1'b0, 16'hFFFF,  1'b1, 1'b0, "t2");
    @(negedge clk);
    do_op(16'h8000,  16'd1,     1'b0, 16'h7FFF,  1'b0, 1'b1, "t3a");
    @(negedge clk);
    do_op(16'h7FFF,  16'hFFFF,  1'b0, 16'h8000,  1'b1, 1'b1, "t3b");
    @(negedge clk);
    do_op(16'd1,     16'hFFFF,  1'b1, 16'h0001,  1'b1, 1'b0, "t4");
    @(negedge clk);

    // start pulse mid-run must be ignored
    A = 16'd100; B = 16'd1; Bi = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    A = 16'd7; B = 16'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0; A = '0; B = '0;
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t5_D", {16'd0, D}, 32'd99);
    repeat (8) @(negedge clk);

    // reset during a run, asserted together with a new start
    A = 16'd5; B = 16'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1; start = 1'b1; A = 16'd9; B = 16'd1;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    check("t5r_D", {16'd0, D}, 32'd0);
    check("t5r_busy", {31'd0, busy}, 32'd0);
    check("t5r_done", {31'd0, done}, 32'd0);
    repeat (8) @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      a  = 16'(i);
      b  = 16'(i + 35);
      bi = (i % 4 != 0);
      if (i == 15) begin
        a = 16'd1;
        b = 16'hFFFF;
      end
      f = {1'b0, a} - {1'b0, b} - {16'd0, bi};
      do_op(a, b, bi, f[15:0], f[16], (a[15] != b[15]) && (f[15] != a[15]), $sformatf("t6_%0d", i));
    end
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
